// File: rtl/adsr_pkg.sv
// Shared types and constant helpers for the multiplexed ADSR envelope generator.
package adsr_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } adsr_state_e;

  // Largest positive value of an env_bits-wide signed envelope.
  function automatic logic [63:0] full_level(input int unsigned env_bits);
    return (64'd1 << (env_bits - 1)) - 64'd1;
  endfunction

  // {1'b0, level, zeros}: places a level input just below the envelope sign bit.
  function automatic logic [63:0] level_ext(input logic [63:0] level,
                                            input int unsigned env_bits,
                                            input int unsigned lvl_bits);
    return level << (env_bits - 1 - lvl_bits);
  endfunction

endpackage

// File: rtl/adsr_step.sv
// Combinational single-voice ADSR next-state/next-envelope step, shared by all slots.
// ADSR_LINEAR_ATTACK_EN selects a constant-step linear attack instead of the one-pole rule.
module adsr_step
  import adsr_pkg::*;
#(
  parameter int unsigned ENV_BITS = 24,
  parameter int unsigned TAU_BITS = 5,
  parameter int unsigned SETTLE   = 256
) (
  input  adsr_state_e         state_i,
  input  logic [ENV_BITS-1:0] env_i,
  input  logic                gate_i,
  input  logic                prev_gate_i,
  input  logic [TAU_BITS-1:0] attack_tau_i,
  input  logic [TAU_BITS-1:0] decay_tau_i,
  input  logic [TAU_BITS-1:0] release_tau_i,
  input  logic [ENV_BITS-1:0] peak_ext_i,
  input  logic [ENV_BITS-1:0] sustain_ext_i,
  output adsr_state_e         state_o,
  output logic [ENV_BITS-1:0] env_o
);

  typedef logic signed [ENV_BITS:0] wide_t;

  localparam wide_t Full   = wide_t'(full_level(ENV_BITS));
  localparam wide_t Settle = wide_t'(SETTLE);

  function automatic wide_t one_pole(input wide_t env, input wide_t target,
                                     input logic [TAU_BITS-1:0] tau);
    wide_t diff;
    diff = target - env;
    return env + (diff >>> tau);
  endfunction

  adsr_state_e eff_state;
  wide_t       env_w, peak_w, sus_w, next_w, diff_w;

  always_comb begin
    env_w  = {1'b0, env_i};
    peak_w = {1'b0, peak_ext_i};
    sus_w  = {1'b0, sustain_ext_i};
    next_w = env_w;
    diff_w = '0;

    // Retrigger keeps the current level; gate-off releases from wherever we are.
    eff_state = state_i;
    if (gate_i && !prev_gate_i) begin
      eff_state = StAttack;
    end else if (!gate_i && (state_i inside {StAttack, StDecay, StSustain})) begin
      eff_state = StRelease;
    end

    state_o = eff_state;
    env_o   = env_i;

    case (eff_state)
      StIdle: env_o = '0;
      StAttack: begin
`ifdef ADSR_LINEAR_ATTACK_EN
        next_w = env_w + (Full >>> attack_tau_i);
`else
        next_w = one_pole(env_w, Full, attack_tau_i);
`endif
        if (next_w >= peak_w) begin
          env_o   = peak_ext_i;
          state_o = StDecay;
        end else begin
          env_o = next_w[ENV_BITS-1:0];
        end
      end
      StDecay: begin
        next_w = one_pole(env_w, sus_w, decay_tau_i);
        diff_w = next_w - sus_w;
        if (diff_w <= Settle && diff_w >= -Settle) begin
          env_o   = sustain_ext_i;
          state_o = StSustain;
        end else begin
          env_o = next_w[ENV_BITS-1:0];
        end
      end
      StSustain: env_o = sustain_ext_i;
      StRelease: begin
        next_w = one_pole(env_w, '0, release_tau_i);
        if (next_w < Settle) begin
          env_o   = '0;
          state_o = StIdle;
        end else begin
          env_o = next_w[ENV_BITS-1:0];
        end
      end
      default: begin
        env_o   = '0;
        state_o = StIdle;
      end
    endcase
  end

endmodule

// File: rtl/adsr_env_mux.sv
// Time-multiplexed multi-voice ADSR envelope generator: one adsr_step serves every voice per tick.
// Build with ADSR_LINEAR_ATTACK_EN for a linear attack ramp.
module adsr_env_mux
  import adsr_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned ENV_BITS   = 24,
  parameter int unsigned TAU_BITS   = 5,
  parameter int unsigned LVL_BITS   = 16,
  parameter int unsigned SETTLE     = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick_i,
  input  logic [NUM_VOICES-1:0]         gate_i,
  input  logic [TAU_BITS-1:0]           attack_tau_i,
  input  logic [TAU_BITS-1:0]           decay_tau_i,
  input  logic [TAU_BITS-1:0]           release_tau_i,
  input  logic [LVL_BITS-1:0]           peak_level_i,
  input  logic [LVL_BITS-1:0]           sustain_level_i,
  output logic                          busy_o,
  output logic                          out_valid_o,
  output logic [$clog2(NUM_VOICES)-1:0] out_voice_o,
  output logic [ENV_BITS-1:0]           out_env_o,
  output logic [NUM_VOICES-1:0]         voice_idle_o,
  output logic                          overrun_o
);

  localparam int unsigned VoiceW = $clog2(NUM_VOICES);
  localparam logic [VoiceW-1:0] LastSlot = VoiceW'(NUM_VOICES - 1);

  adsr_state_e                 state_q [NUM_VOICES];
  logic        [ENV_BITS-1:0]  env_q   [NUM_VOICES];
  logic        [NUM_VOICES-1:0] prev_gate_q;

  logic              busy_q, busy_d;
  logic [VoiceW-1:0] slot_q, slot_d;
  logic              out_valid_q, overrun_q;
  logic [VoiceW-1:0] out_voice_q;
  logic [ENV_BITS-1:0] out_env_q;

  logic [ENV_BITS-1:0] peak_ext, sustain_ext, step_env;
  adsr_state_e         step_state;

  assign peak_ext    = ENV_BITS'(level_ext(64'(peak_level_i), ENV_BITS, LVL_BITS));
  assign sustain_ext = ENV_BITS'(level_ext(64'(sustain_level_i), ENV_BITS, LVL_BITS));

  adsr_step #(
    .ENV_BITS(ENV_BITS),
    .TAU_BITS(TAU_BITS),
    .SETTLE  (SETTLE)
  ) u_step (
    .state_i      (state_q[slot_q]),
    .env_i        (env_q[slot_q]),
    .gate_i       (gate_i[slot_q]),
    .prev_gate_i  (prev_gate_q[slot_q]),
    .attack_tau_i (attack_tau_i),
    .decay_tau_i  (decay_tau_i),
    .release_tau_i(release_tau_i),
    .peak_ext_i   (peak_ext),
    .sustain_ext_i(sustain_ext),
    .state_o      (step_state),
    .env_o        (step_env)
  );

  // Ticks during a sweep are dropped; a tick on the first idle cycle starts the next sweep.
  always_comb begin
    busy_d = busy_q;
    slot_d = slot_q;
    if (busy_q) begin
      if (slot_q == LastSlot) begin
        busy_d = 1'b0;
      end else begin
        slot_d = slot_q + VoiceW'(1);
      end
    end else if (tick_i) begin
      busy_d = 1'b1;
      slot_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= 1'b0;
      slot_q      <= '0;
      out_valid_q <= 1'b0;
      out_voice_q <= '0;
      out_env_q   <= '0;
      overrun_q   <= 1'b0;
      prev_gate_q <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_q[v] <= StIdle;
        env_q[v]   <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      slot_q      <= slot_d;
      out_valid_q <= busy_q;
      if (busy_q) begin
        state_q[slot_q]     <= step_state;
        env_q[slot_q]       <= step_env;
        prev_gate_q[slot_q] <= gate_i[slot_q];
        out_voice_q         <= slot_q;
        out_env_q           <= step_env;
      end
      if (tick_i && busy_q) begin
        overrun_q <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_idle_o[v] = (state_q[v] == StIdle);
    end
  end

  assign busy_o      = busy_q;
  assign out_valid_o = out_valid_q;
  assign out_voice_o = out_voice_q;
  assign out_env_o   = out_env_q;
  assign overrun_o   = overrun_q;

endmodule

// File: doc/adsr_env_mux.md
Name: adsr_env_mux

Overview:
- Time-multiplexed, multi-voice ADSR envelope generator. It is the parametrised successor of the single-voice RC attack/decay/release FSM.
- One shared one-pole update datapath serves NUM_VOICES voices. Per-voice state and envelope are held in register arrays.
- Adds a true SUSTAIN state, a programmable peak level, retrigger-from-current-level, and per-voice idle flags for the voice allocator.
- Sits between the voice allocator (gate source) and the per-voice amplitude multiplier.

Parameters:
- NUM_VOICES, 8, voice count; >= 2.
- ENV_BITS, 24, signed envelope width. MSB is always 0 in the stored value.
- TAU_BITS, 5, shift-amount width.
- LVL_BITS, 16, width of the peak/sustain level inputs; must be <= ENV_BITS-1.
- SETTLE, 256, settle threshold in envelope LSBs.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- tick  in  1  sample strobe; starts one sweep over all voices
- gate  in  NUM_VOICES  per-voice note-on level
- attack_tau  in  TAU_BITS  attack shift
- decay_tau  in  TAU_BITS  decay shift
- release_tau  in  TAU_BITS  release shift
- peak_level  in  LVL_BITS  attack end level
- sustain_level  in  LVL_BITS  sustain level
- busy  out  1  sweep in progress
- out_valid  out  1  out_voice/out_env valid
- out_voice  out  clog2(NUM_VOICES)  voice index
- out_env  out  ENV_BITS  envelope, signed, always >= 0
- voice_idle  out  NUM_VOICES  voice in IDLE
- overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk.
  - Every voice is set to IDLE with env 0 and prev_gate 0.
  - busy=0, out_valid=0, out_voice=0, out_env=0, voice_idle=all ones, overrun=0.
  - Reset mid-sweep aborts the sweep immediately.
- Sweep:
  - tick sampled high with busy=0 at edge T: busy=1 for cycles T+1..T+N (N=NUM_VOICES).
  - Voice k is processed during cycle T+1+k.
  - Its registered result appears as out_valid=1, out_voice=k, out_env=new env during cycle T+2+k.
  - tick while busy=1 is ignored and sets overrun.
  - A tick in the cycle busy falls starts a new sweep.
- Level extension: lvl_ext = {1'b0, level, zeros} to ENV_BITS. FULL = 2^(ENV_BITS-1)-1.
- Update rule for voice k:
  - env_next = env + ((target - env) >>> tau).
  - Difference is computed in ENV_BITS+1 signed bits.
  - tau=0 reaches the target in one step.
- gate[k] is sampled only in voice k's slot. A rising edge is detected against prev_gate[k].
- States and transitions, evaluated per slot in priority order:
  1. Gate rising edge, any state: go to ATTACK. env is kept (no reset to 0) and is updated in this slot with ATTACK rules.
  2. Gate low in ATTACK, DECAY or SUSTAIN: go to RELEASE. env is updated with RELEASE rules.
- Per-state rules:
  - IDLE: env=0. voice_idle[k]=1; cleared in the slot that enters ATTACK.
  - ATTACK: target=FULL, tau=attack_tau. If env_next >= peak_ext: env=peak_ext, go to DECAY.
  - DECAY: target=sustain_ext, tau=decay_tau. If |env_next - sustain_ext| <= SETTLE: env=sustain_ext, go to SUSTAIN. Rising toward a sustain above peak is legal.
  - SUSTAIN: env=sustain_ext every slot, so it tracks live sustain_level changes.
  - RELEASE: target=0, tau=release_tau. If env_next < SETTLE: env=0, go to IDLE, set voice_idle[k].
- Boundary cases:
  - peak_level=0: ATTACK goes to DECAY in the first slot.
  - Gate high for one slot only: the voice enters ATTACK, then RELEASE on the next slot.

Optional Feature:
- Macro ADSR_LINEAR_ATTACK_EN.
- Defined: ATTACK uses env_next = env + (FULL >> attack_tau), a constant step giving a linear ramp. All other states are unchanged.
- Undefined: ATTACK uses the exponential one-pole rule above.

Decomposition:
- Package adsr_pkg holds:
  - state encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4 (3 bits);
  - the FULL constant function;
  - the level-extension function.
- Sub-module adsr_step: a purely combinational single-voice next-state/next-env computation, shared by all slots.
- Top-level holds: the arrays, the sweep counter, gate edge detection, and output registers.

Test Plan (N=4, ENV_BITS=24, LVL_BITS=16, SETTLE=256):
1. Reset, then tick -> out_valid for exactly 4 cycles starting 2 cycles after tick, out_voice 0,1,2,3, out_env all 0, voice_idle=4'b1111.
2. All tau=0, peak=0x8000, sustain=0x4000, gate[0]=1.
   - tick1 -> voice0 env 0x400000, DECAY.
   - tick2 -> 0x200000, SUSTAIN.
   - gate[0]=0, tick3 -> 0, voice_idle[0]=1.
3. attack_tau=1, peak=0x8000 -> tick1 env 0x3FFFFF (ATTACK), tick2 env 0x400000 (DECAY).
4. Voice1 in RELEASE at 0x100000, gate[1] re-raised, attack_tau=0 -> next slot env 0x400000, no drop to 0.
5. tick held high for 3 cycles -> one sweep only; overrun=1 and stays set until rst.
6. Assert rst during slot 2 of a sweep -> next cycle busy=0, out_valid=0, all voices IDLE.
